// File: rtl/tc_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_ctrl
//
// Purpose:
//   Idle-detecting enable controller for an integrated clock-gating cell.
//   The block runs on the free-running source clock and produces the ICG
//   enable. After a programmable number of consecutive idle cycles it gates
//   the downstream clock. Any wake source re-enables the clock, and a level
//   req/ack handshake tells a requester when the gated domain is running
//   again after a fixed settling interval.
//
// Parameters:
//   IdleCycles  consecutive idle cycles spent in DRAIN before gating (>= 1)
//   WakeCycles  cycles spent in WAKE before the domain counts as running (>= 1)
//   CntWidth    derived down-counter width; leave at its default
//
// Ports:
//   clk_i       in   free-running source clock (never the gated clock)
//   rst_i       in   synchronous, active-high reset
//   busy_i      in   downstream domain has outstanding work
//   force_en_i  in   software/debug override that keeps the clock enabled
//   wake_req_i  in   level wake request, held high until wake_ack_o is seen
//   wake_ack_o  out  gated domain is running and the request is granted
//   clk_en_o    out  enable to the ICG en input
//   gated_o     out  status, high while the clock is gated
// -----------------------------------------------------------------------------

// Elaboration-time parameter legality checks, kept apart from the datapath.
module tc_clk_gate_ctrl_param_chk #(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2
) ();

    generate
        if (IdleCycles < 1) begin : g_idle_cycles_bad
            $error("tc_clk_gate_ctrl: IdleCycles must be >= 1");
        end
        if (WakeCycles < 1) begin : g_wake_cycles_bad
            $error("tc_clk_gate_ctrl: WakeCycles must be >= 1");
        end
    endgenerate

endmodule

module tc_clk_gate_ctrl #(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2,
    parameter int CntWidth   = $clog2(((IdleCycles > WakeCycles) ? IdleCycles : WakeCycles) + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic force_en_i,
    input  logic wake_req_i,
    output logic wake_ack_o,
    output logic clk_en_o,
    output logic gated_o
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_OFF   = 2'b10;
    localparam logic [1:0] ST_WAKE  = 2'b11;

    localparam logic [CntWidth-1:0] CNT_ZERO      = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CNT_ONE       = CNT_ZERO + {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CNT_IDLE_LOAD = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] CNT_WAKE_LOAD = CntWidth'(WakeCycles - 1);

    // -------------------------------------------------------------------------
    // Parameter legality
    // -------------------------------------------------------------------------
    tc_clk_gate_ctrl_param_chk #(
        .IdleCycles (IdleCycles),
        .WakeCycles (WakeCycles)
    ) u_param_chk ();

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    // Output flops are loaded from the next state so each output is a clean
    // flop output: a multi-bit state change cannot produce a decode glitch
    // on the ICG enable.
    logic                clk_en_q;
    logic                clk_en_d;
    logic                gated_q;
    logic                gated_d;
    logic                run_q;
    logic                run_d;

    logic                idle_s;
    logic                wake_s;
    logic                cnt_zero_s;

    assign idle_s     = ~busy_i & ~force_en_i & ~wake_req_i;
    assign wake_s     = ~idle_s;
    assign cnt_zero_s = (cnt_q == CNT_ZERO);

    // State, counter and output registers with synchronous reset to RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= CNT_ZERO;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
            run_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            gated_q  <= gated_d;
            run_q    <= run_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (idle_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_IDLE_LOAD;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_DRAIN: begin
                // A wake arriving on the final drain cycle still wins, so the
                // clock is never gated underneath a fresh request.
                if (wake_s) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_zero_s) begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_OFF: begin
                if (wake_s) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_WAKE_LOAD;
                end else begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_WAKE: begin
                // Inputs are deliberately ignored: a started wake always
                // settles fully before the block may drain again.
                if (cnt_zero_s) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_WAKE;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the next state, captured by the output flops.
    always_comb begin
        clk_en_d = 1'b1;
        gated_d  = 1'b0;
        run_d    = 1'b0;
        case (state_d)
            ST_RUN: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                run_d    = 1'b1;
            end
            ST_DRAIN: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                run_d    = 1'b0;
            end
            ST_OFF: begin
                clk_en_d = 1'b0;
                gated_d  = 1'b1;
                run_d    = 1'b0;
            end
            ST_WAKE: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                run_d    = 1'b0;
            end
            default: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                run_d    = 1'b1;
            end
        endcase
    end

    assign clk_en_o   = clk_en_q;
    assign gated_o    = gated_q;
    // The only combinational path: the ack follows the request level so it
    // drops in the same cycle the requester releases wake_req_i.
    assign wake_ack_o = wake_req_i & run_q;

endmodule

// File: doc/tc_clk_gate_ctrl.md
# tc_clk_gate_ctrl

Idle-detecting enable controller for an integrated clock-gating cell. It runs on the free-running source clock and drives the ICG `en_i` input, which is `tc_clk_gating`'s enable. It gates the downstream clock after a programmable idle interval and re-enables it on demand. A level req/ack wake handshake reports to a requester when the gated domain is clocked again after a fixed settling interval.

## Interface

- `IdleCycles`, default 16: consecutive idle cycles required in DRAIN before gating; must be ≥1 (elaboration assertion).
- `WakeCycles`, default 2: cycles spent in WAKE before the domain counts as running; must be ≥1 (elaboration assertion).
- `CntWidth`, default $clog2(max(IdleCycles, WakeCycles)+1): derived counter width; not to be overridden.

- `clk_i` in 1: free-running source clock. Never connect the gated clock here.
- `rst_i` in 1: reset, synchronous and active-high.
- `busy_i` in 1: the downstream domain has outstanding work.
- `force_en_i` in 1: software/debug override that keeps the clock enabled.
- `wake_req_i` in 1: level wake request. The requester holds it high until it sees `wake_ack_o`.
- `wake_ack_o` out 1: the gated domain is running and the request is granted.
- `clk_en_o` out 1: enable to the ICG `en_i`.
- `gated_o` out 1: status; high while the clock is gated.

## Operation

- Idle condition `idle = ~busy_i & ~force_en_i & ~wake_req_i`. Wake condition `wake = ~idle`.
- 2-bit state register and one down-counter `cnt` of width `CntWidth`. All outputs decode from registered state only, with no input-to-output paths. The one exception is `wake_ack_o`, defined below.
- **RUN**: `clk_en_o`=1, `gated_o`=0.
  - If `idle` → DRAIN, `cnt` ← IdleCycles-1.
- **DRAIN**: `clk_en_o`=1, `gated_o`=0.
  - If `wake` → RUN, `cnt` ← 0.
  - Else if `cnt`==0 → OFF.
  - Else `cnt` decrements.
- **OFF**: `clk_en_o`=0, `gated_o`=1.
  - If `wake` → WAKE, `cnt` ← WakeCycles-1.
- **WAKE**: `clk_en_o`=1, `gated_o`=0.
  - If `cnt`==0 → RUN. Else `cnt` decrements.
  - Inputs are ignored here. A wake, once started, always completes to RUN.
- `wake_ack_o = wake_req_i & (state==RUN)`.
  - Combinational in `wake_req_i` only.
  - It drops in the same cycle the requester drops `wake_req_i`.
- While `wake_req_i`, `busy_i` or `force_en_i` is high in RUN, the block remains in RUN.
- Simultaneous events:
  - In DRAIN with `cnt`==0 and `wake` high, wake wins: → RUN, no gating.
  - In RUN, `busy_i` falling in the same cycle `wake_req_i` rises gives not-idle: stay in RUN.
  - In OFF, any one of the three wake sources is sufficient.
- Reset, including mid-DRAIN, OFF or WAKE: the next edge with `rst_i`=1 sets state RUN and `cnt`=0.
- Reset values: `clk_en_o`=1, `gated_o`=0. `wake_ack_o` = `wake_req_i` (state is RUN).
- Test mode bypass is not handled here. `test_en_i` goes straight to the ICG.

## Timing

- Gating latency: if `idle` is first sampled at edge t (RUN→DRAIN) and stays high, OFF is entered at edge t+IdleCycles. `clk_en_o` is low from cycle t+IdleCycles.
- Wake latency from OFF: with `wake` sampled at edge t, the state is WAKE for cycles t..t+WakeCycles-1. RUN is entered at edge t+WakeCycles. `wake_ack_o` is first high in the cycle after edge t+WakeCycles.
- `clk_en_o` rises in the cycle after edge t, so the ICG latch opens while `clk_i` is low in that cycle.
- Wake latency from DRAIN is 1 cycle. From RUN it is 0 cycles, because the ack is combinational.
- `clk_en_o` changes only after rising edges of `clk_i`, which keeps it glitch-free at the ICG latch.

## Test plan

All scenarios use IdleCycles=4 and WakeCycles=2.

- **Reset:** hold `rst_i`=1 for 2 cycles with `wake_req_i`=0 → `clk_en_o`=1, `gated_o`=0, `wake_ack_o`=0. Release with all inputs low → `clk_en_o` falls exactly 4 cycles after the first idle sample.
- **Abort drain:** enter DRAIN, then pulse `busy_i` for 1 cycle when `cnt`=1 → return to RUN. Full 4-cycle idle is needed again, and `gated_o` never rises.
- **Wake from OFF:** assert `wake_req_i` in OFF at edge t → `clk_en_o`=1 from cycle t+1, `wake_ack_o`=1 from cycle t+3. Drop the request → ack falls in the same cycle, and gating follows 4 idle cycles later.
- **Wake/gate collision:** `wake_req_i` rises in the same cycle DRAIN has `cnt`=0 → no OFF entry, RUN next edge, ack 1 cycle later.
- **Override:** `force_en_i`=1 held for 100 cycles → `clk_en_o` stays at 1 throughout. Release → gated after 4 cycles.
- **Reset mid-operation:** `rst_i` asserted during WAKE (`cnt`=1) and also during OFF → state RUN, `clk_en_o`=1 at the next edge, and a fresh 4-cycle drain afterwards.
